// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: load/ALU write-back arbiter with result FIFO and pending scoreboard.
// Optional WB_BYPASS_EN adds a combinational forwarding search over queued and issuing writes.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int NREG       = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            ALU_Valid,
    input  logic [4:0]      ALU_Dest,
    input  logic [31:0]     ALU_Data,
    output logic            ALU_Ready,
    input  logic            LD_Valid,
    input  logic [4:0]      LD_Dest,
    input  logic [31:0]     LD_Data,
    output logic            LD_Ready,
    output logic [4:0]      Add_Dest,
    output logic [31:0]     Write_Data,
    output logic            Write_En,
    output logic [NREG-1:0] Pending,
`ifdef WB_BYPASS_EN
    input  logic [4:0]      Fwd_Addr,
    output logic            Fwd_Hit,
    output logic [31:0]     Fwd_Data,
`endif
    output logic            Err_Addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [36:0]     mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic [SW-1:0]   starve;
    logic [DEPTH-1:0] vld;
    logic            full, force_alu, ld_gnt, ld_x, alu_x, acc, illegal, push, pop;
    logic [4:0]      dest;
    logic [31:0]     data;

    // Load wins unless the ALU has been passed over STARVE_MAX times in a row
    assign full      = count == (AW+1)'(DEPTH);
    assign force_alu = ALU_Valid && starve == SW'(STARVE_MAX);
    assign ld_gnt    = LD_Valid && !force_alu;
    assign LD_Ready  = RST_N && !full && ld_gnt;
    assign ALU_Ready = RST_N && !full && !ld_gnt;
    assign ld_x      = LD_Valid && LD_Ready;
    assign alu_x     = ALU_Valid && ALU_Ready;
    assign acc       = ld_x || alu_x;
    assign dest      = ld_x ? LD_Dest : ALU_Dest;
    assign data      = ld_x ? LD_Data : ALU_Data;
    assign illegal   = int'(dest) >= NREG;
    assign push      = acc && dest != 5'd0 && !illegal;
    assign pop       = count != '0;

    always_ff @(posedge CLK) begin
        if (push) mem[wptr] <= {dest, data};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            starve     <= '0;
            Write_En   <= 1'b0;
            Add_Dest   <= '0;
            Write_Data <= '0;
            Err_Addr   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) begin
                {Add_Dest, Write_Data} <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            Write_En <= pop;
            Err_Addr <= acc && illegal;
            starve   <= (!ALU_Valid || alu_x) ? '0 :
                        (ld_x && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
        end
    end

    always_comb begin
        vld = '0;
        for (int i = 0; i < DEPTH; i++) vld[i] = {1'b0, AW'(i) - rptr} < count;
    end

    always_comb begin
        Pending = '0;
        for (int r = 1; r < NREG; r++) begin
            Pending[r] = Write_En && Add_Dest == 5'(r);
            for (int i = 0; i < DEPTH; i++)
                if (vld[i] && mem[i][36:32] == 5'(r)) Pending[r] = 1'b1;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match wins
    always_comb begin
        logic [AW-1:0] idx;
        idx      = '0;
        Fwd_Hit  = 1'b0;
        Fwd_Data = '0;
        if (Fwd_Addr != 5'd0) begin
            if (Write_En && Add_Dest == Fwd_Addr) begin
                Fwd_Hit  = 1'b1;
                Fwd_Data = Write_Data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rptr + AW'(k);
                if ((AW+1)'(k) < count && mem[idx][36:32] == Fwd_Addr) begin
                    Fwd_Hit  = 1'b1;
                    Fwd_Data = mem[idx][31:0];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_write_arbiter;
    localparam int DEPTH = 4, NREG = 16, SMAX = 3;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        ALU_Valid = 1'b0, LD_Valid = 1'b0;
    logic [4:0]  ALU_Dest = '0, LD_Dest = '0;
    logic [31:0] ALU_Data = '0, LD_Data = '0;
    logic        ALU_Ready, LD_Ready, Write_En, Err_Addr;
    logic [4:0]  Add_Dest;
    logic [31:0] Write_Data;
    logic [15:0] Pending;
`ifdef WB_BYPASS_EN
    logic [4:0]  Fwd_Addr = '0;
    logic        Fwd_Hit;
    logic [31:0] Fwd_Data;
`endif

    wb_write_arbiter #(.DEPTH(DEPTH), .NREG(NREG), .STARVE_MAX(SMAX)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .ALU_Valid(ALU_Valid), .ALU_Dest(ALU_Dest), .ALU_Data(ALU_Data), .ALU_Ready(ALU_Ready),
        .LD_Valid(LD_Valid), .LD_Dest(LD_Dest), .LD_Data(LD_Data), .LD_Ready(LD_Ready),
        .Add_Dest(Add_Dest), .Write_Data(Write_Data), .Write_En(Write_En), .Pending(Pending),
`ifdef WB_BYPASS_EN
        .Fwd_Addr(Fwd_Addr), .Fwd_Hit(Fwd_Hit), .Fwd_Data(Fwd_Data),
`endif
        .Err_Addr(Err_Addr)
    );

    always #5 CLK = ~CLK;

    int passed = 0, total = 0;

    // Reference model: queue of accepted writes plus the issuing slot
    logic [36:0] q[$];
    logic        m_we = 1'b0, m_err = 1'b0;
    logic [4:0]  m_dest = '0;
    logic [31:0] m_data = '0;
    int          m_starve = 0;
    logic        exp_lr, exp_ar;

    function automatic void predict();
        logic lg, rdy;
        lg     = LD_Valid && !(ALU_Valid && m_starve == SMAX);
        rdy    = RST_N && q.size() < DEPTH;
        exp_lr = rdy && lg;
        exp_ar = rdy && !lg;
    endfunction

    function automatic logic [15:0] m_pend();
        logic [15:0] p, one;
        p   = '0;
        one = 16'd1;
        foreach (q[i]) p |= one << q[i][36:32];
        if (m_we) p |= one << m_dest;
        p[0] = 1'b0;
        return p;
    endfunction

`ifdef WB_BYPASS_EN
    function automatic logic [32:0] m_fwd();
        logic [32:0] r;
        r = '0;
        if (Fwd_Addr != 0) begin
            if (m_we && m_dest == Fwd_Addr) r = {1'b1, m_data};
            foreach (q[i]) if (q[i][36:32] == Fwd_Addr) r = {1'b1, q[i][31:0]};
        end
        return r;
    endfunction
`endif

    task automatic tick();
        logic lx, ax;
        logic [4:0] d;
        logic [31:0] dd;
        predict();
        @(posedge CLK);
        if (!RST_N) begin
            q.delete();
            m_we = 0; m_dest = 0; m_data = 0; m_err = 0; m_starve = 0;
        end else begin
            lx = LD_Valid && exp_lr;
            ax = ALU_Valid && exp_ar;
            d  = lx ? LD_Dest : ALU_Dest;
            dd = lx ? LD_Data : ALU_Data;
            m_we = q.size() > 0;
            if (m_we) {m_dest, m_data} = q.pop_front();
            m_err = (lx || ax) && int'(d) >= NREG;
            if ((lx || ax) && d != 0 && int'(d) < NREG) q.push_back({d, dd});
            m_starve = (!ALU_Valid || ax) ? 0 : lx ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : m_starve;
        end
        #1;
    endtask

    task automatic test_reset();
        RST_N = 0;
        #1;
        total++; if (ALU_Ready !== 1'b0) $display("FAIL reset_alu_ready: got %b want 0", ALU_Ready); else passed++;
        total++; if (LD_Ready !== 1'b0) $display("FAIL reset_ld_ready: got %b want 0", LD_Ready); else passed++;
        tick(); tick();
        total++; if (Write_En !== 1'b0) $display("FAIL reset_we: got %b want 0", Write_En); else passed++;
        total++; if (Err_Addr !== 1'b0) $display("FAIL reset_err: got %b want 0", Err_Addr); else passed++;
        total++; if (Pending !== 16'h0) $display("FAIL reset_pending: got %h want 0", Pending); else passed++;
        total++; if ({Add_Dest, Write_Data} !== 37'h0) $display("FAIL reset_out: got %h/%h want 0/0", Add_Dest, Write_Data); else passed++;
        RST_N = 1;
        tick();
    endtask

    task automatic test_single();
        ALU_Valid = 1; ALU_Dest = 5; ALU_Data = 32'hDEADBEEF;
        #1;
        total++; if (ALU_Ready !== 1'b1) $display("FAIL single_ready: got %b want 1", ALU_Ready); else passed++;
        tick();
        ALU_Valid = 0;
        total++; if (Write_En !== 1'b0) $display("FAIL single_we_early: got %b want 0", Write_En); else passed++;
        total++; if (Pending !== 16'h0020) $display("FAIL single_pend1: got %h want 0020", Pending); else passed++;
        tick();
        total++; if (Write_En !== 1'b1) $display("FAIL single_we: got %b want 1", Write_En); else passed++;
        total++; if (Add_Dest !== 5'd5 || Write_Data !== 32'hDEADBEEF) $display("FAIL single_write: got %0d/%h want 5/deadbeef", Add_Dest, Write_Data); else passed++;
        total++; if (Pending !== 16'h0020) $display("FAIL single_pend2: got %h want 0020", Pending); else passed++;
        tick();
        total++; if (Write_En !== 1'b0) $display("FAIL single_we_off: got %b want 0", Write_En); else passed++;
        total++; if (Pending !== 16'h0) $display("FAIL single_pend_off: got %h want 0", Pending); else passed++;
        total++; if (Add_Dest !== 5'd5 || Write_Data !== 32'hDEADBEEF) $display("FAIL single_hold: got %0d/%h want 5/deadbeef", Add_Dest, Write_Data); else passed++;
    endtask

    task automatic test_starve();
        logic [36:0] exp[$];
        logic [36:0] e;
        for (int i = 0; i < 10; i++) begin
            ALU_Valid = 1; ALU_Dest = 5'(3 + i % 2); ALU_Data = 32'h2000_0000 + i;
            LD_Valid = 1;  LD_Dest = 5'(1 + i % 2);  LD_Data = 32'h1000_0000 + i;
            #1;
            total++; if (LD_Ready !== (i % 4 != 3) || ALU_Ready !== (i % 4 == 3))
                $display("FAIL starve_grant%0d: got ld=%b alu=%b want ld=%b", i, LD_Ready, ALU_Ready, i % 4 != 3); else passed++;
            exp.push_back((i % 4 == 3) ? {5'(3 + i % 2), 32'h2000_0000 + i} : {5'(1 + i % 2), 32'h1000_0000 + i});
            tick();
            if (i >= 1) begin
                e = exp.pop_front();
                total++; if (Write_En !== 1'b1 || {Add_Dest, Write_Data} !== e)
                    $display("FAIL starve_write%0d: got we=%b %0d/%h want %0d/%h", i, Write_En, Add_Dest, Write_Data, e[36:32], e[31:0]); else passed++;
            end
        end
        ALU_Valid = 0; LD_Valid = 0;
        tick();
        e = exp.pop_front();
        total++; if (Write_En !== 1'b1 || {Add_Dest, Write_Data} !== e)
            $display("FAIL starve_last: got we=%b %0d/%h want %0d/%h", Write_En, Add_Dest, Write_Data, e[36:32], e[31:0]); else passed++;
        tick();
        total++; if (Write_En !== 1'b0) $display("FAIL starve_drain: got %b want 0", Write_En); else passed++;
    endtask

    task automatic test_filter();
        ALU_Valid = 1; ALU_Dest = 0; ALU_Data = 32'h1234;
        tick();
        ALU_Valid = 0; LD_Valid = 1; LD_Dest = 20; LD_Data = 32'h5678;
        total++; if (Err_Addr !== 1'b0 || Pending !== 16'h0) $display("FAIL filter_x0: got err=%b pend=%h want 0/0", Err_Addr, Pending); else passed++;
        tick();
        LD_Valid = 0;
        total++; if (Err_Addr !== 1'b1) $display("FAIL filter_err: got %b want 1", Err_Addr); else passed++;
        total++; if (Write_En !== 1'b0) $display("FAIL filter_we1: got %b want 0", Write_En); else passed++;
        tick();
        total++; if (Err_Addr !== 1'b0) $display("FAIL filter_err_off: got %b want 0", Err_Addr); else passed++;
        total++; if (Write_En !== 1'b0 || Pending !== 16'h0) $display("FAIL filter_we2: got we=%b pend=%h want 0/0", Write_En, Pending); else passed++;
    endtask

    task automatic test_same_reg();
        ALU_Valid = 1; ALU_Dest = 7; ALU_Data = 32'h1;
        tick();
        ALU_Data = 32'h2;
        total++; if (Pending !== 16'h0080 || Write_En !== 1'b0) $display("FAIL same_e0: got pend=%h we=%b want 0080/0", Pending, Write_En); else passed++;
        tick();
        ALU_Valid = 0;
        total++; if (Write_En !== 1'b1 || Add_Dest !== 5'd7 || Write_Data !== 32'h1) $display("FAIL same_w1: got we=%b %0d/%h want 1 7/1", Write_En, Add_Dest, Write_Data); else passed++;
        total++; if (Pending !== 16'h0080) $display("FAIL same_pend1: got %h want 0080", Pending); else passed++;
`ifdef WB_BYPASS_EN
        Fwd_Addr = 7;
        #1;
        total++; if (Fwd_Hit !== 1'b1 || Fwd_Data !== 32'h2) $display("FAIL same_fwd: got %b/%h want 1/2", Fwd_Hit, Fwd_Data); else passed++;
        Fwd_Addr = 0;
`endif
        tick();
        total++; if (Write_En !== 1'b1 || Add_Dest !== 5'd7 || Write_Data !== 32'h2) $display("FAIL same_w2: got we=%b %0d/%h want 1 7/2", Write_En, Add_Dest, Write_Data); else passed++;
        total++; if (Pending !== 16'h0080) $display("FAIL same_pend2: got %h want 0080", Pending); else passed++;
        tick();
        total++; if (Write_En !== 1'b0 || Pending !== 16'h0) $display("FAIL same_end: got we=%b pend=%h want 0/0", Write_En, Pending); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            ALU_Valid = 1; ALU_Dest = 5'(9 + i); ALU_Data = 32'hA0 + i;
            tick();
        end
        ALU_Valid = 0; RST_N = 0;
        #1;
        total++; if (ALU_Ready !== 1'b0 || LD_Ready !== 1'b0) $display("FAIL mid_ready: got alu=%b ld=%b want 0/0", ALU_Ready, LD_Ready); else passed++;
        tick();
        RST_N = 1;
        total++; if (Write_En !== 1'b0 || Pending !== 16'h0) $display("FAIL mid_clear: got we=%b pend=%h want 0/0", Write_En, Pending); else passed++;
        tick();
        total++; if (Write_En !== 1'b0 || Pending !== 16'h0) $display("FAIL mid_discard: got we=%b pend=%h want 0/0", Write_En, Pending); else passed++;
        ALU_Valid = 1; ALU_Dest = 12; ALU_Data = 32'hC0FFEE;
        tick();
        ALU_Valid = 0;
        total++; if (Pending !== 16'h1000 || Write_En !== 1'b0) $display("FAIL mid_pend: got %h we=%b want 1000/0", Pending, Write_En); else passed++;
        tick();
        total++; if (Write_En !== 1'b1 || Add_Dest !== 5'd12 || Write_Data !== 32'hC0FFEE) $display("FAIL mid_write: got we=%b %0d/%h want 1 12/c0ffee", Write_En, Add_Dest, Write_Data); else passed++;
        tick();
    endtask

    task automatic test_random();
`ifdef WB_BYPASS_EN
        logic [32:0] f;
`endif
        for (int n = 0; n < 400; n++) begin
            RST_N     = ($urandom % 40) != 0;
            ALU_Valid = ($urandom % 4) != 0;
            LD_Valid  = ($urandom % 3) != 0;
            ALU_Dest  = ($urandom % 8 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 15));
            LD_Dest   = ($urandom % 8 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 15));
            ALU_Data  = $urandom;
            LD_Data   = $urandom;
`ifdef WB_BYPASS_EN
            Fwd_Addr  = 5'($urandom_range(0, 15));
`endif
            #1;
            predict();
            total++; if (LD_Ready !== exp_lr || ALU_Ready !== exp_ar)
                $display("FAIL rnd_ready%0d: got ld=%b alu=%b want ld=%b alu=%b", n, LD_Ready, ALU_Ready, exp_lr, exp_ar); else passed++;
`ifdef WB_BYPASS_EN
            f = m_fwd();
            total++; if ({Fwd_Hit, Fwd_Data} !== f) $display("FAIL rnd_fwd%0d: got %b/%h want %b/%h", n, Fwd_Hit, Fwd_Data, f[32], f[31:0]); else passed++;
`endif
            tick();
            total++; if (Write_En !== m_we || Add_Dest !== m_dest || Write_Data !== m_data)
                $display("FAIL rnd_write%0d: got %b %0d/%h want %b %0d/%h", n, Write_En, Add_Dest, Write_Data, m_we, m_dest, m_data); else passed++;
            total++; if (Pending !== m_pend()) $display("FAIL rnd_pend%0d: got %h want %h", n, Pending, m_pend()); else passed++;
            total++; if (Err_Addr !== m_err) $display("FAIL rnd_err%0d: got %b want %b", n, Err_Addr, m_err); else passed++;
        end
        RST_N = 1; ALU_Valid = 0; LD_Valid = 0;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_filter();
        test_same_reg();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
